// File: rtl/vga_fb_pkg.sv
// Shared constants and the slot/tag encoding for the framebuffer arbiter.
package vga_fb_pkg;

  localparam int unsigned H_RES       = 320;
  localparam int unsigned V_RES       = 240;
  localparam int unsigned SCALE_SHIFT = 1;
  localparam int unsigned AW          = 17;
  localparam int unsigned DW          = 12;

  // What the RAM slot was used for; follows ram_dout down the pipeline.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_DISP  = 2'd1,
    TAG_BLANK = 2'd2,
    TAG_RD    = 2'd3
  } tag_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Requester bus: game-logic write port and CPU/debug read port.
interface vga_fb_arbiter_if;
  import vga_fb_pkg::*;

  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_data, rd_data_valid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_data, rd_data_valid
  );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Maps a screen coordinate to a framebuffer address (downscaled by SCALE_SHIFT).
module vga_fb_addr_gen
  import vga_fb_pkg::*;
(
  input  logic          visible,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  output logic [AW-1:0] addr,
  output logic          in_range
);

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);

  logic [9:0] fx_s;
  logic [9:0] fy_s;

  assign fx_s = pixel_x >> SCALE_SHIFT;
  assign fy_s = pixel_y >> SCALE_SHIFT;

  // Row-major address; only meaningful (and overflow-free) when in range.
  always_comb begin
    addr     = {AW{1'b0}};
    in_range = 1'b0;
    if (visible && (fx_s < H_LIM) && (fy_s < V_LIM)) begin
      in_range = 1'b1;
      addr     = AW'(fy_s) * AW'(H_RES) + AW'(fx_s);
    end else begin
      in_range = 1'b0;
      addr     = {AW{1'b0}};
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns p_tick cycles,
// write and read share the rest round-robin.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             visible,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  vga_fb_arbiter_if.slave  req,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout,
  output logic [DW-1:0]    pixel_rgb,
  output logic             pixel_valid
);

  logic [AW-1:0] disp_addr_s;
  logic          disp_in_range_s;
  logic          grant_wr_s;
  logic          grant_rd_s;
  tag_e          tag_s;
  tag_e          tag1_r;
  logic          rr_prefer_rd_r;   // 1: read wins the next contention
  logic [DW-1:0] pixel_rgb_r;
  logic          pixel_valid_r;
  logic [DW-1:0] rd_data_r;
  logic          rd_data_valid_r;

  vga_fb_addr_gen u_addr_gen (
    .visible  (visible),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .addr     (disp_addr_s),
    .in_range (disp_in_range_s)
  );

  // Slot decision and combinational RAM drive; reset forces an idle slot.
  always_comb begin
    tag_s      = TAG_NONE;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = {AW{1'b0}};
    ram_din    = {DW{1'b0}};
    if (reset) begin
      tag_s = TAG_NONE;
    end else if (p_tick) begin
      if (disp_in_range_s) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr_s;
        tag_s    = TAG_DISP;
      end else begin
        tag_s = TAG_BLANK;
      end
    end else if (req.wr_valid && (!req.rd_valid || !rr_prefer_rd_r)) begin
      grant_wr_s = 1'b1;
      ram_en     = 1'b1;
      ram_we     = 1'b1;
      ram_addr   = req.wr_addr;
      ram_din    = req.wr_data;
    end else if (req.rd_valid) begin
      grant_rd_s = 1'b1;
      ram_en     = 1'b1;
      ram_addr   = req.rd_addr;
      tag_s      = TAG_RD;
    end else begin
      tag_s = TAG_NONE;
    end
  end

  assign req.wr_ready = grant_wr_s;
  assign req.rd_ready = grant_rd_s;

  // Round-robin pointer (moves only on a grant) and stage-1 tag aligned with ram_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_prefer_rd_r <= 1'b0;
      tag1_r         <= TAG_NONE;
    end else begin
      tag1_r <= tag_s;
      if (grant_wr_s) begin
        rr_prefer_rd_r <= 1'b1;
      end else if (grant_rd_s) begin
        rr_prefer_rd_r <= 1'b0;
      end else begin
        rr_prefer_rd_r <= rr_prefer_rd_r;
      end
    end
  end

  // Stage-2 output registers: route ram_dout by tag; rd_data holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_rgb_r     <= {DW{1'b0}};
      pixel_valid_r   <= 1'b0;
      rd_data_r       <= {DW{1'b0}};
      rd_data_valid_r <= 1'b0;
    end else begin
      case (tag1_r)
        TAG_DISP: begin
          pixel_rgb_r     <= ram_dout;
          pixel_valid_r   <= 1'b1;
          rd_data_valid_r <= 1'b0;
        end
        TAG_BLANK: begin
          pixel_rgb_r     <= {DW{1'b0}};
          pixel_valid_r   <= 1'b1;
          rd_data_valid_r <= 1'b0;
        end
        TAG_RD: begin
          rd_data_r       <= ram_dout;
          rd_data_valid_r <= 1'b1;
          pixel_valid_r   <= 1'b0;
        end
        default: begin
          pixel_valid_r   <= 1'b0;
          rd_data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_rgb         = pixel_rgb_r;
  assign pixel_valid       = pixel_valid_r;
  assign req.rd_data       = rd_data_r;
  assign req.rd_data_valid = rd_data_valid_r;

endmodule
